// File: rtl/cpu_clk_step_ctrl.sv
// cpu_clk_step_ctrl: board-level CPU clock controller for the MIPS core FPGA tops.
//
// Divides iClk by DIV into a CPU clock (oCpuClk) with a matching one-iClk pulse
// (oTick) per emitted CPU cycle. Supports three modes:
//   RUN  - a tick is emitted every DIV cycles
//   STEP - one tick per debounced press of the step button
//   HALT - the divider is frozen at 0 and oCpuClk is held low
// Emitted cycles are counted, and one of NCH LED channels is registered onto oLED.
//
// Optional breakpoint: define CPU_CLK_BREAK_EN to add iPC, iBrkAddr, iBrkValid
// and oBrkHit. A breakpoint match at a RUN period end suppresses that tick and
// freezes RUN until the mode is changed to STEP or HALT.
//
// Ports:
//   iClk       board clock
//   iRst_n     asynchronous active-low reset
//   iMode      00 HALT, 01 RUN, 10 STEP, 11 HALT
//   iStep      raw step button (asynchronous, active-high, bouncy)
//   iCntClr    synchronous clear of the cycle counter
//   iSel       LED channel select
//   iChan      LED channels; channel k is at bits [k*LED_W +: LED_W]
//   oCpuClk    divided clock to the core
//   oTick      one-iClk pulse per emitted CPU cycle
//   oCycleCnt  count of emitted CPU cycles
//   oStepPend  step armed but not yet emitted
//   oLED       selected channel (one cycle of latency)
module cpu_clk_step_ctrl #(
  parameter int unsigned DIV        = 20,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NCH        = 4,
  parameter int unsigned LED_W      = 8
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic [1:0]               iMode,
  input  logic                     iStep,
  input  logic                     iCntClr,
  input  logic [$clog2(NCH)-1:0]   iSel,
  input  logic [NCH*LED_W-1:0]     iChan,
`ifdef CPU_CLK_BREAK_EN
  input  logic [31:0]              iPC,
  input  logic [31:0]              iBrkAddr,
  input  logic                     iBrkValid,
  output logic                     oBrkHit,
`endif
  output logic                     oCpuClk,
  output logic                     oTick,
  output logic [CNT_W-1:0]         oCycleCnt,
  output logic                     oStepPend,
  output logic [LED_W-1:0]         oLED
);

  localparam int unsigned DivW = $clog2(DIV);
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned SelW = $clog2(NCH);

  logic [DivW-1:0]  divCntQ;
  logic             sync1Q, sync2Q;
  logic             debLvlQ;
  logic [DebW-1:0]  debCntQ;

  logic             modeRun, modeStep, modeHalt;
  logic             periodEnd, halfPoint, runAllowed, emit;
  logic             debDiff, debDone, stepReq;
  logic [LED_W-1:0] ledD;

  // 2'b11 is deliberately decoded as HALT.
  assign modeRun  = (iMode == 2'b01);
  assign modeStep = (iMode == 2'b10);
  assign modeHalt = !modeRun && !modeStep;

  assign periodEnd = !modeHalt && (divCntQ == DivW'(DIV - 1));
  // Last cycle of the high phase: divCnt becomes DIV/2 at the next edge.
  assign halfPoint = (divCntQ == DivW'(DIV / 2 - 1));

`ifdef CPU_CLK_BREAK_EN
  // A match at the period end suppresses the tick in the same cycle it is seen.
  assign runAllowed = !oBrkHit && !(iBrkValid && (iPC == iBrkAddr));
`else
  assign runAllowed = 1'b1;
`endif

  assign emit = periodEnd && ((modeRun && runAllowed) || (modeStep && oStepPend));

  // Debounce: accept the synced level after DEB_CYCLES consecutive differing samples.
  assign debDiff = (sync2Q != debLvlQ);
  assign debDone = debDiff && (debCntQ == DebW'(DEB_CYCLES - 1));
  assign stepReq = debDone && sync2Q;

  always_comb begin
    ledD = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (iSel == SelW'(k)) begin
        ledD = iChan[k*LED_W +: LED_W];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      divCntQ   <= '0;
      sync1Q    <= 1'b0;
      sync2Q    <= 1'b0;
      debLvlQ   <= 1'b0;
      debCntQ   <= '0;
      oCpuClk   <= 1'b0;
      oTick     <= 1'b0;
      oCycleCnt <= '0;
      oStepPend <= 1'b0;
      oLED      <= '0;
`ifdef CPU_CLK_BREAK_EN
      oBrkHit   <= 1'b0;
`endif
    end else begin
      sync1Q <= iStep;
      sync2Q <= sync1Q;

      if (!debDiff) begin
        debCntQ <= '0;
      end else if (debDone) begin
        debLvlQ <= sync2Q;
        debCntQ <= '0;
      end else begin
        debCntQ <= debCntQ + DebW'(1);
      end

      if (modeHalt || periodEnd) begin
        divCntQ <= '0;
      end else begin
        divCntQ <= divCntQ + DivW'(1);
      end

      oTick <= emit;

      // HALT aborts any high phase immediately.
      if (modeHalt) begin
        oCpuClk <= 1'b0;
      end else if (emit) begin
        oCpuClk <= 1'b1;
      end else if (halfPoint) begin
        oCpuClk <= 1'b0;
      end

      // A press while already pending is dropped, not queued.
      if (!modeStep) begin
        oStepPend <= 1'b0;
      end else if (oStepPend) begin
        if (emit) begin
          oStepPend <= 1'b0;
        end
      end else if (stepReq) begin
        oStepPend <= 1'b1;
      end

      if (iCntClr) begin
        oCycleCnt <= '0;
      end else if (emit) begin
        oCycleCnt <= oCycleCnt + CNT_W'(1);
      end

      oLED <= ledD;

`ifdef CPU_CLK_BREAK_EN
      // Leaving RUN releases the breakpoint so STEP can move past it.
      if (!modeRun) begin
        oBrkHit <= 1'b0;
      end else if (periodEnd && iBrkValid && (iPC == iBrkAddr)) begin
        oBrkHit <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cpu_clk_step_ctrl.sv
// Testbench for cpu_clk_step_ctrl with DIV=4, DEB_CYCLES=3, CNT_W=4, NCH=4, LED_W=8.
// Randomized and phased stimulus is checked every cycle against a behavioural model.
module tb_cpu_clk_step_ctrl;

  localparam int unsigned DIV  = 4;
  localparam int unsigned DEB  = 3;
  localparam int unsigned CNTW = 4;
  localparam int unsigned NCH  = 4;
  localparam int unsigned LEDW = 8;

  logic              iClk    = 1'b0;
  logic              iRst_n  = 1'b0;
  logic [1:0]        iMode   = 2'b00;
  logic              iStep   = 1'b0;
  logic              iCntClr = 1'b0;
  logic [1:0]        iSel    = 2'b00;
  logic [31:0]       iChan   = 32'h0;
  logic              oCpuClk, oTick, oStepPend;
  logic [CNTW-1:0]   oCycleCnt;
  logic [LEDW-1:0]   oLED;
`ifdef CPU_CLK_BREAK_EN
  logic [31:0]       iPC       = 32'h0;
  logic [31:0]       iBrkAddr  = 32'h40;
  logic              iBrkValid = 1'b0;
  logic              oBrkHit;
`endif

  cpu_clk_step_ctrl #(
    .DIV        (DIV),
    .DEB_CYCLES (DEB),
    .CNT_W      (CNTW),
    .NCH        (NCH),
    .LED_W      (LEDW)
  ) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iMode     (iMode),
    .iStep     (iStep),
    .iCntClr   (iCntClr),
    .iSel      (iSel),
    .iChan     (iChan),
`ifdef CPU_CLK_BREAK_EN
    .iPC       (iPC),
    .iBrkAddr  (iBrkAddr),
    .iBrkValid (iBrkValid),
    .oBrkHit   (oBrkHit),
`endif
    .oCpuClk   (oCpuClk),
    .oTick     (oTick),
    .oCycleCnt (oCycleCnt),
    .oStepPend (oStepPend),
    .oLED      (oLED)
  );

  always #5 iClk = ~iClk;

  int nTests = 0;
  int nFail  = 0;
  int dutTicks = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model. Time within a CPU period, remaining high cycles of the
  // CPU clock, and a window of recent synced button samples.
  int mPhase, mHighLeft, mCnt, mLed;
  bit mPend, mTick, mS1, mS2, mLvl;
  bit hist[$];

  task automatic modelReset();
    mPhase = 0; mHighLeft = 0; mCnt = 0; mLed = 0;
    mPend = 0; mTick = 0; mS1 = 0; mS2 = 0; mLvl = 0;
    hist.delete();
  endtask

  task automatic modelEdge(input logic [1:0] mode, input bit st, input bit clr,
                           input logic [1:0] sel, input logic [31:0] chan);
    bit run, stp, halt, emit, press, allSame;
    run  = (mode == 2'd1);
    stp  = (mode == 2'd2);
    halt = !run && !stp;
    emit = !halt && (mPhase == DIV - 1) && (run || (stp && mPend));

    // Level accepted once the last DEB synced samples all disagree with it.
    press = 0;
    hist.push_back(mS2);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      allSame = 1;
      foreach (hist[i]) if (hist[i] == mLvl) allSame = 0;
      if (allSame) begin
        mLvl  = !mLvl;
        press = mLvl;
        hist.delete();
      end
    end
    mS2 = mS1;
    mS1 = st;

    if (!stp)       mPend = 0;
    else if (mPend) mPend = emit ? 0 : 1;
    else if (press) mPend = 1;

    if (clr)       mCnt = 0;
    else if (emit) mCnt = (mCnt + 1) % (1 << CNTW);

    mTick = emit;
    if (halt)               mHighLeft = 0;
    else if (emit)          mHighLeft = DIV / 2;
    else if (mHighLeft > 0) mHighLeft--;

    mPhase = halt ? 0 : (mPhase + 1) % DIV;
    mLed   = (sel < NCH) ? int'((chan >> (sel * LEDW)) & 32'hFF) : 0;
  endtask

  task automatic compareAll();
    checkEq("tick",    32'(oTick),     32'(mTick));
    checkEq("cpuClk",  32'(oCpuClk),   32'(mHighLeft > 0));
    checkEq("cnt",     32'(oCycleCnt), 32'(mCnt));
    checkEq("stepPend", 32'(oStepPend), 32'(mPend));
    checkEq("led",     32'(oLED),      32'(mLed));
`ifdef CPU_CLK_BREAK_EN
    checkEq("brkHit",  32'(oBrkHit),   32'd0);
`endif
  endtask

  task automatic drive(input logic [1:0] mode, input bit st, input bit clr,
                       input logic [1:0] sel, input logic [31:0] chan);
    iMode = mode; iStep = st; iCntClr = clr; iSel = sel; iChan = chan;
    modelEdge(mode, st, clr, sel, chan);
    @(posedge iClk);
    #1;
    if (oTick === 1'b1) dutTicks++;
    compareAll();
  endtask

  task automatic pulseReset();
    iRst_n = 1'b0;
    modelReset();
    #1;
    compareAll();
    @(posedge iClk);
    #1;
    compareAll();
    iRst_n = 1'b1;
  endtask

  logic [1:0] curMode;
  bit         curStep;

  initial begin
    modelReset();
    #12;
    compareAll();
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;

    // RUN from reset: one tick per DIV cycles, LED on a fixed channel set.
    dutTicks = 0;
    for (int i = 0; i < 40; i++) begin
      drive(2'd1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'hDDCC_BBAA);
    end
    checkEq("runTicks40", 32'(dutTicks), 32'(40 / DIV));

    // Keep running past the counter wrap, with occasional clears.
    for (int i = 0; i < 40; i++) begin
      drive(2'd1, 1'b0, ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), $urandom);
    end

    // STEP with a bouncy button: bounce, hold high, hold low.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 5; i++) drive(2'd2, 1'($urandom), 1'b0, 2'(r), 32'hDDCC_BBAA);
      for (int i = 0; i < 10; i++) drive(2'd2, 1'b1, 1'b0, 2'(r), 32'hDDCC_BBAA);
      for (int i = 0; i < 10; i++) drive(2'd2, 1'b0, 1'b0, 2'(r), 32'hDDCC_BBAA);
    end

    // RUN then HALT mid high phase, then back to RUN.
    for (int i = 0; i < 5; i++) drive(2'd1, 1'b0, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 6; i++) drive(2'd0, 1'b0, 1'b0, 2'd1, 32'h0);
    for (int i = 0; i < 9; i++) drive(2'd1, 1'b0, 1'b0, 2'd2, 32'h0);

    // Fully random traffic including mid-run resets.
    curMode = 2'd1;
    curStep = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) curMode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) curStep = !curStep;
      drive(curMode, curStep, ($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 149) == 0) pulseReset();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
